// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI read-channel arbiter onto a single RAM slave, one burst in flight
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    // master 0: instruction fetch
    input  logic [ID_WIDTH-1:0]   m0_arid,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [ID_WIDTH-1:0]   m0_rid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    // master 1: data
    input  logic [ID_WIDTH-1:0]   m1_arid,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [ID_WIDTH-1:0]   m1_rid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    // shared slave
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [ID_WIDTH-1:0]   s_rid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    // status
    output logic                  owner,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state;
    logic                  prio;
    logic                  owner_q;
    logic                  err_q;
    logic [7:0]            cnt;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;

    logic grant;
    logic in_data;
    logic fwd0;
    logic fwd1;
    logic beat;

    // Pick the lone requester, or the round-robin favourite when both ask
    always_comb begin
        grant = prio;
        if (m0_arvalid && !m1_arvalid) begin
            grant = 1'b0;
        end else if (m1_arvalid && !m0_arvalid) begin
            grant = 1'b1;
        end
    end

    assign m0_arready = (state == IDLE) && !grant && m0_arvalid;
    assign m1_arready = (state == IDLE) &&  grant && m1_arvalid;

    assign in_data = (state == DATA);
    assign fwd0    = in_data && !owner_q;
    assign fwd1    = in_data &&  owner_q;
    assign s_rready = in_data && (owner_q ? m1_rready : m0_rready);
    assign beat     = s_rvalid && s_rready;

    // Read beats go only to the owner; the other master sees all zeros
    always_comb begin
        m0_rvalid = fwd0 && s_rvalid;
        m0_rid    = fwd0 ? s_rid   : '0;
        m0_rdata  = fwd0 ? s_rdata : '0;
        m0_rresp  = fwd0 ? s_rresp : '0;
        m0_rlast  = fwd0 && s_rlast;
        m1_rvalid = fwd1 && s_rvalid;
        m1_rid    = fwd1 ? s_rid   : '0;
        m1_rdata  = fwd1 ? s_rdata : '0;
        m1_rresp  = fwd1 ? s_rresp : '0;
        m1_rlast  = fwd1 && s_rlast;
    end

    assign s_arvalid = (state == ADDR);
    assign s_arid    = ar_id;
    assign s_araddr  = ar_addr;
    assign s_arlen   = ar_len;
    assign s_arsize  = ar_size;
    assign s_arburst = ar_burst;

    assign owner = owner_q;
    assign busy  = (state != IDLE);
    assign err   = err_q;

    // Arbitration FSM: latch the winner's request, issue it, then stream its beats until rlast
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= 8'd0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arready) begin
                        owner_q  <= 1'b0;
                        ar_id    <= m0_arid;
                        ar_addr  <= m0_araddr;
                        ar_len   <= m0_arlen;
                        ar_size  <= m0_arsize;
                        ar_burst <= m0_arburst;
                        state    <= ADDR;
                    end else if (m1_arready) begin
                        owner_q  <= 1'b1;
                        ar_id    <= m1_arid;
                        ar_addr  <= m1_araddr;
                        ar_len   <= m1_arlen;
                        ar_size  <= m1_arsize;
                        ar_burst <= m1_arburst;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        cnt   <= 8'd0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt <= cnt + 8'd1;
                        // Early or missing rlast is only flagged; rlast alone ends the burst
                        if (s_rlast != (cnt == ar_len)) begin
                            err_q <= 1'b1;
                        end
                        if (s_rlast) begin
                            prio  <= ~owner_q;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [IW-1:0] m0_arid, m1_arid, m0_rid, m1_rid, s_arid, s_rid;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic [2:0]    m0_arsize, m1_arsize, s_arsize;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst;
    logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rlast, m1_rlast, s_rlast;
    logic          m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic          s_arvalid, s_arready;
    logic          owner, busy, err;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .owner(owner), .busy(busy), .err(err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting for a request, 1 request offered to slave, 2 beats flowing
    int            m_on = 0;
    int            m_phase, m_owner, m_prio, m_beats, m_err;
    logic [IW-1:0] l_id;
    logic [AW-1:0] l_addr;
    logic [7:0]    l_len;
    logic [2:0]    l_size;
    logic [1:0]    l_burst;
    logic          e_ar0, e_ar1, e_dat, e_fwd0, e_fwd1;

    function automatic logic wins0();
        return m0_arvalid && (!m1_arvalid || m_prio == 0);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_on = 1; m_phase = 0; m_owner = 0; m_prio = 0; m_beats = 0; m_err = 0;
            l_id = '0; l_addr = '0; l_len = '0; l_size = '0; l_burst = '0;
        end else if (m_on != 0) begin
            if (m_phase == 0 && (m0_arvalid || m1_arvalid)) begin
                m_owner = wins0() ? 0 : 1;
                l_id    = m_owner == 0 ? m0_arid    : m1_arid;
                l_addr  = m_owner == 0 ? m0_araddr  : m1_araddr;
                l_len   = m_owner == 0 ? m0_arlen   : m1_arlen;
                l_size  = m_owner == 0 ? m0_arsize  : m1_arsize;
                l_burst = m_owner == 0 ? m0_arburst : m1_arburst;
                m_phase = 1;
            end else if (m_phase == 1 && s_arready) begin
                m_phase = 2;
                m_beats = 0;
            end else if (m_phase == 2 && s_rvalid && (m_owner == 0 ? m0_rready : m1_rready)) begin
                // beat index m_beats: rlast must coincide with the arlen-th beat
                if (s_rlast && m_beats != int'(l_len)) m_err = 1;
                if (!s_rlast && m_beats == int'(l_len)) m_err = 1;
                m_beats = (m_beats + 1) % 256;
                if (s_rlast) begin
                    m_phase = 0;
                    m_prio  = 1 - m_owner;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_on != 0) begin
            e_ar0  = (m_phase == 0) && wins0();
            e_ar1  = (m_phase == 0) && m1_arvalid && !wins0();
            e_dat  = (m_phase == 2);
            e_fwd0 = e_dat && m_owner == 0;
            e_fwd1 = e_dat && m_owner == 1;
            chk("m0_arready", 64'(m0_arready), 64'(e_ar0));
            chk("m1_arready", 64'(m1_arready), 64'(e_ar1));
            chk("s_arvalid", 64'(s_arvalid), 64'(m_phase == 1));
            if (m_phase == 1) begin
                chk("s_arid", 64'(s_arid), 64'(l_id));
                chk("s_araddr", 64'(s_araddr), 64'(l_addr));
                chk("s_arlen", 64'(s_arlen), 64'(l_len));
                chk("s_arsize", 64'(s_arsize), 64'(l_size));
                chk("s_arburst", 64'(s_arburst), 64'(l_burst));
            end
            chk("s_rready", 64'(s_rready), 64'(e_dat && (m_owner == 0 ? m0_rready : m1_rready)));
            chk("m0_rvalid", 64'(m0_rvalid), 64'(e_fwd0 && s_rvalid));
            chk("m1_rvalid", 64'(m1_rvalid), 64'(e_fwd1 && s_rvalid));
            if (e_dat) begin
                chk("m0_rdata", m0_rdata, e_fwd0 ? s_rdata : 64'd0);
                chk("m1_rdata", m1_rdata, e_fwd1 ? s_rdata : 64'd0);
                chk("m0_rid", 64'(m0_rid), e_fwd0 ? 64'(s_rid) : 64'd0);
                chk("m1_rid", 64'(m1_rid), e_fwd1 ? 64'(s_rid) : 64'd0);
                chk("m0_rresp", 64'(m0_rresp), e_fwd0 ? 64'(s_rresp) : 64'd0);
                chk("m1_rresp", 64'(m1_rresp), e_fwd1 ? 64'(s_rresp) : 64'd0);
                chk("m0_rlast", 64'(m0_rlast), 64'(e_fwd0 && s_rlast));
                chk("m1_rlast", 64'(m1_rlast), 64'(e_fwd1 && s_rlast));
            end
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("owner", 64'(owner), 64'(m_owner));
            chk("err", 64'(err), 64'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic h0, h1, hb;
    logic c_ar0, c_ar1, c_sarv, c_srr, c_rv0, c_rv1, c_busy, c_err, c_rl0;
    logic [AW-1:0] c_saddr;
    logic [DW-1:0] c_rd0, c_rd1;

    // one clock: snapshot at the falling edge, change inputs 1 unit after the rising edge
    task automatic cyc();
        @(negedge clock);
        h0 = m0_arvalid && m0_arready;
        h1 = m1_arvalid && m1_arready;
        hb = s_rvalid && s_rready;
        c_ar0 = m0_arready; c_ar1 = m1_arready; c_sarv = s_arvalid; c_saddr = s_araddr;
        c_srr = s_rready; c_rv0 = m0_rvalid; c_rv1 = m1_rvalid; c_busy = busy; c_err = err;
        c_rd0 = m0_rdata; c_rd1 = m1_rdata; c_rl0 = m0_rlast;
        @(posedge clock);
        #1;
        if (h0) m0_arvalid = 1'b0;
        if (h1) m1_arvalid = 1'b0;
    endtask

    task automatic req(input int m, input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len);
        if (m == 0) begin
            m0_arid = id; m0_araddr = a; m0_arlen = len; m0_arsize = 3'd3; m0_arburst = 2'd1; m0_arvalid = 1'b1;
        end else begin
            m1_arid = id; m1_araddr = a; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'd1; m1_arvalid = 1'b1;
        end
    endtask

    task automatic wait_grant(input int m);
        int n = 0;
        cyc();
        while (!(m == 0 ? h0 : h1) && n < 20) begin cyc(); n++; end
        chk("grant_timeout", 64'(m == 0 ? h0 : h1), 64'd1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [IW-1:0] id);
        int n = 0;
        s_rvalid = 1'b1; s_rdata = d; s_rlast = last; s_rid = id; s_rresp = d[1:0];
        cyc();
        while (!hb && n < 20) begin cyc(); n++; end
        chk("beat_timeout", 64'(hb), 64'd1);
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    int k;
    logic [DW-1:0] got [4];

    initial begin
        m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0;
        m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0;
        s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;

        // reset state
        cyc();
        chk("rst_busy", 64'(c_busy), 64'd0);
        chk("rst_err", 64'(c_err), 64'd0);
        chk("rst_sarvalid", 64'(c_sarv), 64'd0);
        chk("rst_srready", 64'(c_srr), 64'd0);

        // m0 alone, single beat at 0x100
        req(0, 4'h1, 20'h00100, 8'd0);
        cyc();
        chk("s1_m0_arready", 64'(c_ar0), 64'd1);
        cyc();
        chk("s1_sarvalid", 64'(c_sarv), 64'd1);
        chk("s1_saraddr", 64'(c_saddr), 64'h100);
        send_beat(64'h0000_00A0, 1'b1, 4'h1);
        chk("s1_m0_rvalid", 64'(c_rv0), 64'd1);
        chk("s1_m0_rdata", c_rd0, 64'hA0);
        chk("s1_m0_rlast", 64'(c_rl0), 64'd1);
        cyc();
        chk("s1_busy_drop", 64'(c_busy), 64'd0);
        // prio now favours m1
        req(0, 4'h2, 20'h00200, 8'd0);
        req(1, 4'h3, 20'h00300, 8'd0);
        cyc();
        chk("s1_prio_m1", 64'(c_ar1), 64'd1);
        chk("s1_prio_m0", 64'(c_ar0), 64'd0);
        send_beat(64'hB0, 1'b1, 4'h3);
        wait_grant(0);
        send_beat(64'hB1, 1'b1, 4'h2);

        // simultaneous requests from reset, then alternation
        reset = 1'b1; cyc(); reset = 1'b0;
        req(0, 4'h4, 20'h00400, 8'd1);
        req(1, 4'h5, 20'h00500, 8'd0);
        cyc();
        chk("s2_m0_first", 64'(c_ar0), 64'd1);
        chk("s2_m1_waits", 64'(c_ar1), 64'd0);
        send_beat(64'hC0, 1'b0, 4'h4);
        chk("s2_m1_no_rvalid", 64'(c_rv1), 64'd0);
        send_beat(64'hC1, 1'b1, 4'h4);
        cyc();
        chk("s2_m1_next_idle", 64'(c_ar1), 64'd1);
        send_beat(64'hC2, 1'b1, 4'h5);
        req(0, 4'h6, 20'h00600, 8'd0);
        req(1, 4'h7, 20'h00700, 8'd0);
        cyc();
        chk("s2_alt_m0", 64'(c_ar0), 64'd1);
        chk("s2_alt_m1", 64'(c_ar1), 64'd0);
        send_beat(64'hC3, 1'b1, 4'h6);
        wait_grant(1);
        send_beat(64'hC4, 1'b1, 4'h7);

        // m1 asks while m0 owns the slave
        req(0, 4'h8, 20'h00800, 8'd2);
        cyc();
        chk("s6_m0_grant", 64'(c_ar0), 64'd1);
        req(1, 4'h9, 20'h00900, 8'd0);
        for (int i = 0; i < 3; i++) begin
            send_beat(64'hD0 + 64'(i), i == 2, 4'h8);
            chk("s6_m1_arready", 64'(c_ar1), 64'd0);
            chk("s6_m1_rvalid", 64'(c_rv1), 64'd0);
            chk("s6_m0_rvalid", 64'(c_rv0), 64'd1);
        end
        cyc();
        chk("s6_m1_granted", 64'(c_ar1), 64'd1);
        send_beat(64'hD8, 1'b1, 4'h9);

        // m1 four-beat burst, slave stalls AR, master rready toggles
        s_arready = 1'b0;
        req(1, 4'hA, 20'h0A000, 8'd3);
        cyc();
        chk("s3_grant", 64'(c_ar1), 64'd1);
        cyc();
        chk("s3_ar_hold0", 64'(c_sarv), 64'd1);
        cyc();
        chk("s3_ar_hold1", 64'(c_saddr), 64'h0A000);
        s_arready = 1'b1;
        cyc();
        k = 0;
        s_rvalid = 1'b1; s_rid = 4'hA;
        for (int i = 0; i < 20 && k < 4; i++) begin
            m1_rready = (i % 2 == 0);
            s_rdata = 64'h1111_0000 + 64'(k);
            s_rlast = (k == 3);
            cyc();
            chk("s3_rready_mirror", 64'(c_srr), 64'(i % 2 == 0));
            if (hb) begin
                got[k] = c_rd1;
                k++;
            end
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; m1_rready = 1'b1;
        chk("s3_beats", 64'(k), 64'd4);
        chk("s3_beat0", got[0], 64'h1111_0000);
        chk("s3_beat1", got[1], 64'h1111_0001);
        chk("s3_beat2", got[2], 64'h1111_0002);
        chk("s3_beat3", got[3], 64'h1111_0003);
        cyc();
        chk("s3_err", 64'(c_err), 64'd0);
        chk("s3_idle", 64'(c_busy), 64'd0);

        // early rlast on beat 2 of an arlen=3 burst
        req(0, 4'hB, 20'h0B000, 8'd3);
        wait_grant(0);
        send_beat(64'hE0, 1'b0, 4'hB);
        send_beat(64'hE1, 1'b0, 4'hB);
        send_beat(64'hE2, 1'b1, 4'hB);
        cyc();
        chk("s4_err_set", 64'(c_err), 64'd1);
        chk("s4_idle", 64'(c_busy), 64'd0);
        req(0, 4'hC, 20'h0C000, 8'd0);
        wait_grant(0);
        send_beat(64'hF0, 1'b1, 4'hC);
        cyc();
        chk("s4_err_sticky", 64'(c_err), 64'd1);

        // reset in the middle of an m1 burst (prio was 1, err was 1)
        req(1, 4'hD, 20'h0D000, 8'd3);
        wait_grant(1);
        send_beat(64'h90, 1'b0, 4'hD);
        send_beat(64'h91, 1'b0, 4'hD);
        s_rvalid = 1'b1; s_rdata = 64'h92; s_rid = 4'hD;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("s5_busy", 64'(c_busy), 64'd0);
        chk("s5_rv0", 64'(c_rv0), 64'd0);
        chk("s5_rv1", 64'(c_rv1), 64'd0);
        chk("s5_ar0", 64'(c_ar0), 64'd0);
        chk("s5_ar1", 64'(c_ar1), 64'd0);
        chk("s5_srready", 64'(c_srr), 64'd0);
        chk("s5_err", 64'(c_err), 64'd0);
        s_rvalid = 1'b0; s_rdata = '0; s_rid = '0;
        req(0, 4'hE, 20'h0E000, 8'd0);
        req(1, 4'hF, 20'h0F000, 8'd0);
        cyc();
        chk("s5_prio0", 64'(c_ar0), 64'd1);
        send_beat(64'h93, 1'b1, 4'hE);
        wait_grant(1);
        send_beat(64'h94, 1'b1, 4'hF);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 20, AR address width.
- DATA_WIDTH, 64, R data width.
- ID_WIDTH, 4, AR/R ID width.

REQ-002 Ports, one per line: name, direction, width, meaning. N = 0 (instruction fetch), 1 (data). Clock and reset are listed first.
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- mN_arid/araddr/arlen/arsize/arburst, in, ID_WIDTH/ADDR_WIDTH/8/3/2, master N read-request payload.
- mN_arvalid, in, 1, master N request valid.
- mN_arready, out, 1, master N request accepted.
- mN_rid/rdata/rresp/rlast, out, ID_WIDTH/DATA_WIDTH/2/1, read beat to master N.
- mN_rvalid, out, 1, beat valid to master N.
- mN_rready, in, 1, master N accepts beat.
- s_arid/araddr/arlen/arsize/arburst, out, same widths as mN, request to the shared RAM slave.
- s_arvalid, out, 1, slave request valid.
- s_arready, in, 1, slave accepts request.
- s_rid/rdata/rresp/rlast, in, same widths as mN, slave read beat.
- s_rvalid, in, 1, slave beat valid.
- s_rready, out, 1, arbiter accepts slave beat.
- owner, out, 1, master currently holding the slave.
- busy, out, 1, state != IDLE.
- err, out, 1, sticky rlast/arlen mismatch flag.

Function
REQ-003 FSM states SHALL be IDLE, ADDR and DATA; only one outstanding burst SHALL exist at any time.
REQ-004 In IDLE, grant SHALL go to the only requester if one mN_arvalid is high; if both are high, grant SHALL go to master prio.
REQ-005 mN_arready SHALL be combinational, equal to (state==IDLE && grant==N && mN_arvalid); the non-granted master's arready SHALL be 0.
REQ-006 On the mN_arvalid && mN_arready handshake, the arbiter SHALL register the payload and owner=N, and SHALL enter ADDR on the next cycle.
REQ-007 In ADDR, s_arvalid SHALL be 1 with the registered payload held stable; on s_arready, the FSM SHALL enter DATA and clear beat counter cnt to 0.
REQ-008 s_arvalid SHALL be 0 outside ADDR; AR latency from master handshake to s_arvalid SHALL be exactly 1 cycle.
REQ-009 In DATA, the following SHALL hold:
- m[owner]_rvalid = s_rvalid, s_rready = m[owner]_rready.
- s_rid/rdata/rresp/rlast SHALL be forwarded to the owner.
- The non-owner SHALL see rvalid=0 and rdata/rid/rresp/rlast=0.
REQ-010 Outside DATA, s_rready and both mN_rvalid SHALL be 0.
REQ-011 Each s_rvalid && s_rready beat SHALL increment 8-bit cnt.
REQ-012 Burst end SHALL be triggered only by a beat with s_rlast=1, which SHALL return the FSM to IDLE and set prio = ~owner (round robin).
REQ-013 err SHALL be set when either of these occurs:
- a beat with s_rlast=1 arrives with cnt != registered arlen;
- a beat with s_rlast=0 arrives with cnt == arlen.
err SHALL remain set until reset and SHALL NOT alter the FSM.
REQ-014 A new request arriving while busy SHALL wait with its arready=0 and SHALL be arbitrated in the first IDLE cycle after the burst ends (no bubble beyond that cycle).
REQ-015 Requests withdrawn in IDLE before the handshake SHALL NOT change prio.

Reset
REQ-016 When reset=1 at a clock edge, the arbiter SHALL set state=IDLE, prio=0, owner=0, cnt=0, err=0, with all valid/ready outputs 0 in the following cycle.
REQ-017 Reset mid-burst SHALL abandon the burst immediately; no beat SHALL be forwarded after reset, and slave-side cleanup SHALL be the system's responsibility via the shared reset.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- m0 alone, araddr=0x100, arlen=0 -> m0_arready=1 in cycle 0; s_arvalid at cycle 1 with araddr=0x100; one beat to m0 with rlast=1; busy then drops; prio=1.
- m0 and m1 request together from reset -> m0 granted first; after m0's rlast, m1 is granted in the next IDLE cycle; then simultaneous requests again -> m0 granted (alternation).
- m1 burst arlen=3 with m1_rready toggling 1,0,1,0 -> s_rready mirrors the toggling; 4 beats delivered in order; cnt reaches 3; err=0.
- Slave asserts rlast on beat 2 of an arlen=3 burst -> err=1 and FSM returns to IDLE; a subsequent clean burst leaves err=1.
- reset pulsed while in DATA after 2 of 4 beats -> next cycle busy=0, all rvalid/arready=0, prio=0, err=0.
- m1 asserts arvalid during an m0 burst -> m1_arready stays 0 until the burst ends; m1 never sees rvalid for m0's beats.
